// File: rtl/vga_layer_renderer_if.sv
// Write port bundle for the rectangle table of vga_layer_renderer.
// The master side is the game/pose logic; the slave side is the renderer.
interface vga_layer_renderer_if #(
  parameter int NRECT = 16,
  parameter int CW    = 4
);
  localparam int IW = (NRECT > 1) ? $clog2(NRECT) : 1;

  logic            wr_valid;
  logic            wr_ready;
  logic [IW-1:0]   wr_idx;
  logic [9:0]      wr_left;
  logic [9:0]      wr_right;
  logic [9:0]      wr_top;
  logic [9:0]      wr_bot;
  logic [3*CW-1:0] wr_color;
  logic            wr_enable;

  modport master (
    output wr_valid, wr_idx, wr_left, wr_right, wr_top, wr_bot, wr_color, wr_enable,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_idx, wr_left, wr_right, wr_top, wr_bot, wr_color, wr_enable,
    output wr_ready
  );
endinterface

// File: rtl/vga_layer_renderer.sv
// VGA timing generator with a prioritised rectangle-layer renderer (2-stage pixel pipeline).
// Optional feature macro: SHADOW_TABLE_EN (double-buffered table, committed once per frame).
module vga_layer_renderer #(
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYN    = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 11,
  parameter int VSYN    = 2,
  parameter int VBP     = 32,
  parameter int NRECT   = 16,
  parameter int CW      = 4,
  parameter logic [3*CW-1:0] BG_RGB = '0
) (
  input  logic                    vgaclk,
  input  logic                    reset,
  vga_layer_renderer_if.slave     wr,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    sync_b,
  output logic                    blank_b,
  output logic                    frame_start,
  output logic [CW-1:0]           r,
  output logic [CW-1:0]           g,
  output logic [CW-1:0]           b
);

  localparam int IW   = (NRECT > 1) ? $clog2(NRECT) : 1;
  localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
  localparam int VMAX = VACTIVE + VFP + VSYN + VBP;

  localparam logic [9:0] H_LAST   = 10'(HMAX - 1);
  localparam logic [9:0] V_LAST   = 10'(VMAX - 1);
  localparam logic [9:0] H_ACT    = 10'(HACTIVE);
  localparam logic [9:0] V_ACT    = 10'(VACTIVE);
  localparam logic [9:0] HS_START = 10'(HACTIVE + HFP);
  localparam logic [9:0] HS_END   = 10'(HACTIVE + HFP + HSYN);
  localparam logic [9:0] VS_START = 10'(VACTIVE + VFP);
  localparam logic [9:0] VS_END   = 10'(VACTIVE + VFP + VSYN);

  typedef struct packed {
    logic            en;
    logic [9:0]      left;
    logic [9:0]      right;
    logic [9:0]      top;
    logic [9:0]      bot;
    logic [3*CW-1:0] color;
  } rect_t;

  rect_t           r_act [NRECT];
  logic [9:0]      r_hcnt;
  logic [9:0]      r_vcnt;
  logic            w_hEnd;
  logic            w_vEnd;
  logic            w_wrFire;
  logic            w_idxOk;
  rect_t           w_wrEntry;
  logic            w_hs0;
  logic            w_vs0;
  logic            w_bl0;
  logic            w_fs0;
  logic [NRECT-1:0] r_hit;
  logic            r_hs1;
  logic            r_vs1;
  logic            r_bl1;
  logic            r_fs1;
  logic [3*CW-1:0] w_winColor;
  logic [3*CW-1:0] r_rgb;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_blank;
  logic            r_fs;

  assign w_hEnd    = (r_hcnt == H_LAST);
  assign w_vEnd    = (r_vcnt == V_LAST);
  assign w_wrFire  = wr.wr_valid & wr.wr_ready;
  assign w_wrEntry = {wr.wr_enable, wr.wr_left, wr.wr_right, wr.wr_top, wr.wr_bot, wr.wr_color};

  // Indices past NRECT are accepted but dropped; a full power-of-two table has none.
  if (NRECT == (1 << IW)) begin : g_fullIdx
    assign w_idxOk = 1'b1;
  end else begin : g_partIdx
    assign w_idxOk = (wr.wr_idx < IW'(NRECT));
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_hEnd) begin
      r_hcnt <= '0;
      r_vcnt <= w_vEnd ? 10'd0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 10'd1;
    end
  end

`ifdef SHADOW_TABLE_EN
  // Writes land in the shadow copy; the last counter cycle of a frame publishes it whole.
  rect_t r_shadow [NRECT];
  logic  w_commit;

  assign w_commit    = w_hEnd & w_vEnd;
  assign wr.wr_ready = ~w_commit;

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NRECT; i++) begin
        r_shadow[i] <= '0;
        r_act[i]    <= '0;
      end
    end else begin
      if (w_wrFire && w_idxOk) r_shadow[wr.wr_idx] <= w_wrEntry;
      if (w_commit) begin
        for (int i = 0; i < NRECT; i++) r_act[i] <= r_shadow[i];
      end
    end
  end
`else
  assign wr.wr_ready = 1'b1;

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NRECT; i++) r_act[i] <= '0;
    end else if (w_wrFire && w_idxOk) begin
      r_act[wr.wr_idx] <= w_wrEntry;
    end
  end
`endif

  assign w_hs0 = ~((r_hcnt >= HS_START) && (r_hcnt < HS_END));
  assign w_vs0 = ~((r_vcnt >= VS_START) && (r_vcnt < VS_END));
  assign w_bl0 = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_fs0 = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_hit <= '0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_bl1 <= 1'b0;
      r_fs1 <= 1'b0;
    end else begin
      for (int i = 0; i < NRECT; i++) begin
        r_hit[i] <= r_act[i].en &&
                    (r_hcnt >= r_act[i].left) && (r_hcnt < r_act[i].right) &&
                    (r_vcnt >= r_act[i].top)  && (r_vcnt < r_act[i].bot);
      end
      r_hs1 <= w_hs0;
      r_vs1 <= w_vs0;
      r_bl1 <= w_bl0;
      r_fs1 <= w_fs0;
    end
  end

  // Scanning from the top index down leaves the lowest-index hit as the winner.
  always_comb begin
    w_winColor = BG_RGB;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (r_hit[i]) w_winColor = r_act[i].color;
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_blank <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_rgb   <= r_bl1 ? w_winColor : '0;
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
      r_blank <= r_bl1;
      r_fs    <= r_fs1;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign sync_b      = 1'b0;
  assign blank_b     = r_blank;
  assign frame_start = r_fs;
  assign r           = r_rgb[3*CW-1:2*CW];
  assign g           = r_rgb[2*CW-1:CW];
  assign b           = r_rgb[CW-1:0];

endmodule

// File: tb/tb_vga_layer_renderer.sv
// Scoreboard bench for vga_layer_renderer on a shrunken raster so many frames fit in a short run.
// A frame-level reference model predicts every output pixel; a monitor compares them each cycle.
module tb_vga_layer_renderer;

  localparam int HA  = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA  = 12, VFP = 1, VSY = 2, VBP = 2;
  localparam int NR  = 6;
  localparam int CW  = 4;
  localparam logic [11:0] BG = 12'h125;
  localparam int HMAX  = HA + HFP + HSY + HBP;
  localparam int VMAX  = VA + VFP + VSY + VBP;
  localparam int FRAME = HMAX * VMAX;
  localparam logic [16:0] RESET_EXP = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};

  typedef struct {
    bit          en;
    int          l, rr, t, bt;
    logic [11:0] c;
  } mrect_t;

  logic vgaclk;
  logic reset = 1'b0;
  logic hsync, vsync, sync_b, blank_b, frame_start;
  logic [CW-1:0] r, g, b;

  vga_layer_renderer_if #(.NRECT(NR), .CW(CW)) wrIf ();

  vga_layer_renderer #(
    .HACTIVE(HA), .HFP(HFP), .HSYN(HSY), .HBP(HBP),
    .VACTIVE(VA), .VFP(VFP), .VSYN(VSY), .VBP(VBP),
    .NRECT(NR), .CW(CW), .BG_RGB(BG)
  ) dut (
    .vgaclk(vgaclk), .reset(reset), .wr(wrIf),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .frame_start(frame_start), .r(r), .g(g), .b(b)
  );

  initial vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  int          total = 0;
  int          bad   = 0;
  mrect_t      mAct [NR];
  mrect_t      mSh  [NR];
  int          mh = 0, mv = 0;
  bit          modelOn  = 0;
  bit          checking = 0;
  logic [16:0] expQ [$];
  logic [16:0] expItem;
  int          cyc = 0, lastFs = 0;
  bit          fsSeen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h (model x=%0d y=%0d) t=%0t", name, act, exp, mh, mv, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL timeout %s actual=expired expected=event t=%0t", name, $time);
  endtask

  function automatic logic [16:0] modelPixel(input int x, input int y);
    logic [11:0] c;
    bit vis, hs, vs, fs;
    vis = (x < HA) && (y < VA);
    c = BG;
    for (int i = NR - 1; i >= 0; i--)
      if (mAct[i].en && x >= mAct[i].l && x < mAct[i].rr && y >= mAct[i].t && y < mAct[i].bt)
        c = mAct[i].c;
    if (!vis) c = 12'h000;
    hs = !(x >= HA + HFP && x < HA + HFP + HSY);
    vs = !(y >= VA + VFP && y < VA + VFP + VSY);
    fs = (x == 0) && (y == 0);
    return {1'b0, hs, vs, vis, fs, c};
  endfunction

  function automatic bit modelReady();
`ifdef SHADOW_TABLE_EN
    return !(mh == HMAX - 1 && mv == VMAX - 1);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < NR; i++) begin
      mAct[i] = '{0, 0, 0, 0, 0, 12'h000};
      mSh[i]  = '{0, 0, 0, 0, 0, 12'h000};
    end
    mh = 0;
    mv = 0;
  endfunction

  // Reference model: each edge the pixel at the current raster position enters the pipe.
  initial forever begin
    @(posedge vgaclk);
    if (modelOn && !reset) begin
      bit rdy;
      mrect_t e;
      rdy = modelReady();
      expQ.push_back(modelPixel(mh, mv));
      if (wrIf.wr_valid && rdy && int'(wrIf.wr_idx) < NR) begin
        e = '{wrIf.wr_enable, int'(wrIf.wr_left), int'(wrIf.wr_right),
              int'(wrIf.wr_top), int'(wrIf.wr_bot), wrIf.wr_color};
`ifdef SHADOW_TABLE_EN
        mSh[wrIf.wr_idx] = e;
`else
        mAct[wrIf.wr_idx] = e;
`endif
      end
`ifdef SHADOW_TABLE_EN
      if (mh == HMAX - 1 && mv == VMAX - 1)
        for (int i = 0; i < NR; i++) mAct[i] = mSh[i];
`endif
      if (mh == HMAX - 1) begin
        mh = 0;
        mv = (mv == VMAX - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  // Monitor: compares every presented pixel against the scoreboard head.
  initial forever begin
    @(negedge vgaclk);
    if (checking) begin
      cyc++;
      if (reset) begin
        checkOutput("resetHold", 32'({sync_b, hsync, vsync, blank_b, frame_start, r, g, b}), 32'(RESET_EXP));
      end else if (expQ.size() == 0) begin
        reportTimeout("scoreboardEmpty");
      end else begin
        expItem = expQ.pop_front();
        checkOutput("pixel", 32'({sync_b, hsync, vsync, blank_b, frame_start, r, g, b}), 32'(expItem));
        if (frame_start) begin
          if (fsSeen) checkOutput("framePeriod", 32'(cyc - lastFs), 32'(FRAME));
          lastFs = cyc;
          fsSeen = 1;
        end
      end
      checkOutput("wrReady", 32'(wrIf.wr_ready), 32'(modelReady()));
    end
  end

  task automatic doReset();
    @(posedge vgaclk);
    #1;
    reset    = 1'b1;
    checking = 1;
    modelOn  = 0;
    expQ.delete();
    clearModel();
    fsSeen = 0;
    #1;
    checkOutput("resetAsync", 32'({sync_b, hsync, vsync, blank_b, frame_start, r, g, b}), 32'(RESET_EXP));
    checkOutput("resetReady", 32'(wrIf.wr_ready), 32'd1);
    repeat (3) @(posedge vgaclk);
    #1;
    reset = 1'b0;
    expQ.push_back(RESET_EXP);
    expQ.push_back(RESET_EXP);
    modelOn = 1;
  endtask

  task automatic waitLine(input int y);
    int n;
    n = 0;
    do begin
      @(negedge vgaclk);
      n++;
    end while (!(mv == y && mh == 0) && n < 2 * FRAME);
    if (n >= 2 * FRAME) reportTimeout("waitLine");
  endtask

  // mode 0: any cycle, 1: during horizontal blanking, 2: on the commit cycle.
  task automatic applyStimulus(input int idx, input int l, input int rr, input int t, input int bt,
                               input logic [11:0] col, input bit en, input int mode);
    int n;
    n = 0;
    @(negedge vgaclk);
    if (mode == 2) begin
      while (!(mh == HMAX - 1 && mv == VMAX - 1) && n < 2 * FRAME) begin
        @(negedge vgaclk);
        n++;
      end
    end else if (mode == 1) begin
`ifndef SHADOW_TABLE_EN
      while (!(mh >= HA && mh <= HMAX - 2) && n < 2 * FRAME) begin
        @(negedge vgaclk);
        n++;
      end
`endif
    end
    if (n >= 2 * FRAME) reportTimeout("writeWindow");
    wrIf.wr_idx    = 3'(idx);
    wrIf.wr_left   = 10'(l);
    wrIf.wr_right  = 10'(rr);
    wrIf.wr_top    = 10'(t);
    wrIf.wr_bot    = 10'(bt);
    wrIf.wr_color  = col;
    wrIf.wr_enable = en;
    wrIf.wr_valid  = 1'b1;
    n = 0;
    while (!wrIf.wr_ready && n < 10) begin
      @(negedge vgaclk);
      n++;
    end
    if (n >= 10) reportTimeout("wrReady");
    @(posedge vgaclk);
    #1;
    wrIf.wr_valid = 1'b0;
  endtask

  task automatic runFrames(input int n);
    repeat (n * FRAME) @(posedge vgaclk);
  endtask

  initial begin
    #(FRAME * 10 * 40);
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wrIf.wr_valid  = 1'b0;
    wrIf.wr_idx    = '0;
    wrIf.wr_left   = '0;
    wrIf.wr_right  = '0;
    wrIf.wr_top    = '0;
    wrIf.wr_bot    = '0;
    wrIf.wr_color  = '0;
    wrIf.wr_enable = 1'b0;

    doReset();
    runFrames(2);

    waitLine(5);
    applyStimulus(0, 6, 10, 3, 7, 12'hFFF, 1, 1);
    runFrames(2);

    applyStimulus(3, 0, 6, 0, 6, 12'hF00, 1, 1);
    applyStimulus(1, 3, 9, 3, 9, 12'h0F0, 1, 1);
    runFrames(2);

    applyStimulus(2, 10, 14, 8, 11, 12'h00F, 1, 2);
    runFrames(3);

    applyStimulus(4, 12, 20, 10, 14, 12'hFFF, 1, 1);
    applyStimulus(5, 5, 5, 0, 12, 12'h0F0, 1, 1);
    applyStimulus(6, 0, 20, 0, 20, 12'hABC, 1, 1);
    applyStimulus(7, 0, 20, 0, 20, 12'h987, 1, 1);
    runFrames(2);

    waitLine(5);
    doReset();
    runFrames(2);

    for (int k = 0; k < 25; k++) begin
      applyStimulus($urandom_range(0, 7), $urandom_range(0, HMAX), $urandom_range(0, HMAX),
                    $urandom_range(0, VMAX), $urandom_range(0, VMAX),
                    12'($urandom_range(0, 4095)), $urandom_range(0, 3) != 0, 1);
      repeat ($urandom_range(0, 60)) @(negedge vgaclk);
    end
    runFrames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
